i_wr_sram_reader: RTL and testbench
===================================

Name: i_wr_sram_reader

Overview:
- Front end of the image-write path. Walks a stored image in SRAM in raster order: row by row, and column by column within each row.
- Issues one SRAM read per pixel, absorbs the fixed 1-cycle SRAM read latency, and presents pixels to the downstream writer over a valid/ready stream.
- Carries its own column and row counters and tags end-of-row and end-of-frame so the consumer needs no counting of its own.

Parameters:
- DIM_BITS, 13, width of the image width/height fields and of the column/row counters.
- ADDR_BITS, 26, SRAM word address width.
- DATA_BITS, 32, SRAM word / pixel width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  1-cycle pulse that starts a frame; ignored while busy=1.
- img_width  input  DIM_BITS  pixels per row; sampled when start is accepted.
- img_height  input  DIM_BITS  rows per frame; sampled when start is accepted.
- base_addr  input  ADDR_BITS  SRAM word address of pixel (0,0); sampled when start is accepted.
- sram_rd_en  output  1  SRAM read strobe.
- sram_addr  output  ADDR_BITS  SRAM read address; valid while sram_rd_en=1.
- sram_rdata  input  DATA_BITS  read data; valid exactly 1 cycle after sram_rd_en.
- pix_data  output  DATA_BITS  pixel to the downstream writer.
- pix_valid  output  1  pix_data is valid.
- pix_ready  input  1  downstream accepts the pixel.
- pix_eol  output  1  current pixel is the last column of its row.
- pix_eof  output  1  current pixel is the last pixel of the frame.
- busy  output  1  a frame is in progress.
- done  output  1  1-cycle pulse when the frame is complete.

Behaviour:
- Reset: outputs are reset to sram_rd_en=0, sram_addr=0, pix_valid=0, pix_data=0, pix_eol=0, pix_eof=0, busy=0 and done=0. FSM goes to IDLE, counters go to 0, the 2-entry output buffer is emptied, and any in-flight read is discarded.
- Reset mid-frame: identical to reset. SRAM data returning in the cycle after rst is dropped.
- FSM states and transitions:
  - IDLE -> READ on start when img_width!=0 and img_height!=0. The start cycle latches width, height and base, and sets busy=1 in the next cycle.
  - IDLE -> DONE on start when img_width==0 or img_height==0. No reads are issued.
  - READ: issues reads. When the final address has been issued, go to DRAIN.
  - DRAIN: no new reads. When the buffer is empty, nothing is in flight, and the eof pixel has been accepted, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Issue rule:
  - In READ, sram_rd_en=1 when (buffered entries + in-flight reads - pop this cycle) < 2. A pop occurs when pix_valid && pix_ready.
  - This guarantees the buffer never overflows and sustains 1 pixel/cycle while pix_ready is held high.
- Address generation:
  - The first read is to base_addr; each later read is previous + 1, wrapping modulo 2^ADDR_BITS.
  - Column runs 0..width-1 and wraps to 0. On that wrap, row increments.
  - The final read is the one at column=width-1 and row=height-1.
  - No multiplier is used; the address is incremental.
- Tagging:
  - eol and eof are computed at issue time and travel with the data through the in-flight stage and the buffer.
  - pix_eol=1 when the pixel is at column width-1; pix_eof=1 when it is the final pixel.
- Latency: start accepted in cycle 0 -> first sram_rd_en in cycle 1 -> sram_rdata in cycle 2 -> pix_valid=1 in cycle 3.
- Output hold: the buffer is a 2-entry FIFO. While pix_valid=1 and pix_ready=0, pix_data, pix_eol and pix_eof hold stable.
- done timing: done pulses in the cycle after the eof pixel is accepted.
- start while busy=1: ignored, with no effect on the current frame.

Test Plan:
- Basic frame: width=4, height=2, base=0x100, pix_ready=1.
  - Reads go to 0x100..0x107 in consecutive cycles 1..8.
  - 8 pixels appear in cycles 3..10.
  - pix_eol is set on pixels 3 and 7; pix_eof on pixel 7 only.
  - done pulses in cycle 11.
- Backpressure: width=3, height=1, pix_ready=0 during cycles 3..7.
  - At most 2 reads are outstanding plus buffered.
  - pix_data holds the first pixel unchanged.
  - After release, 3 pixels arrive in order, with no loss or duplication.
- Zero dimension: width=0, height=5, start pulse.
  - sram_rd_en is never asserted and no pix_valid occurs.
  - done pulses in cycle 1.
- Address wrap: base=0x3FFFFFE, width=4, height=1 -> reads go to 0x3FFFFFE, 0x3FFFFFF, 0x0000000, 0x0000001.
- Reset mid-frame: width=8, height=8, rst asserted in cycle 6.
  - In the next cycle all outputs are at their reset values and busy=0.
  - No pix_valid occurs from the read in flight at reset.
  - A new start then behaves exactly as the basic frame.
- Start during busy: a second start in cycle 4 with width=4, height=2.
  - It is ignored: only 8 pixels are produced and there is a single done pulse.

Source files
------------

// File: rtl/i_wr_sram_reader_if.sv
// i_wr_sram_reader_if: start/geometry, SRAM read port and pixel stream of the raster SRAM reader.
interface i_wr_sram_reader_if #(
    parameter int DIM_BITS  = 13,
    parameter int ADDR_BITS = 26,
    parameter int DATA_BITS = 32
);
    logic                 start;
    logic [DIM_BITS-1:0]  img_width;
    logic [DIM_BITS-1:0]  img_height;
    logic [ADDR_BITS-1:0] base_addr;
    logic                 sram_rd_en;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [DATA_BITS-1:0] sram_rdata;
    logic [DATA_BITS-1:0] pix_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_eol;
    logic                 pix_eof;
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, img_width, img_height, base_addr, sram_rdata, pix_ready,
        output sram_rd_en, sram_addr, pix_data, pix_valid, pix_eol, pix_eof, busy, done
    );

    modport master (
        output start, img_width, img_height, base_addr, sram_rdata, pix_ready,
        input  sram_rd_en, sram_addr, pix_data, pix_valid, pix_eol, pix_eof, busy, done
    );
endinterface

// File: rtl/i_wr_sram_reader.sv
// i_wr_sram_reader: walks an image in SRAM in raster order and streams pixels tagged with eol/eof.
module i_wr_sram_reader #(
    parameter int DIM_BITS  = 13,
    parameter int ADDR_BITS = 26,
    parameter int DATA_BITS = 32
) (
    input logic               clk,
    input logic               rst,
    i_wr_sram_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                    r_state, w_next;
    logic [DIM_BITS-1:0]       r_width, r_height, r_col, r_row;
    logic [ADDR_BITS-1:0]      r_addr;
    logic                      r_inf, r_inf_eol, r_inf_eof;
    logic [1:0][DATA_BITS-1:0] r_data;
    logic [1:0]                r_eol, r_eof, r_cnt, w_occ;
    logic                      r_wp, r_rp;
    logic                      w_valid, w_pop, w_issue, w_last_col, w_last;

    always_comb begin
        w_valid    = r_cnt != 2'd0;
        w_pop      = w_valid && bus.pix_ready;
        // buffered + in-flight after this cycle's pop must leave room for the new read
        w_occ      = r_cnt + {1'b0, r_inf} - {1'b0, w_pop};
        w_issue    = r_state == READ && w_occ < 2'd2;
        w_last_col = r_col == r_width - 1'b1;
        w_last     = w_last_col && r_row == r_height - 1'b1;
        w_next     = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = (bus.img_width != '0 && bus.img_height != '0) ? READ : DONE;
            READ:    if (w_issue && w_last) w_next = DRAIN;
            DRAIN:   if (w_pop && r_eof[r_rp]) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_width   <= '0;
            r_height  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_inf     <= 1'b0;
            r_inf_eol <= 1'b0;
            r_inf_eof <= 1'b0;
            r_data    <= '0;
            r_eol     <= '0;
            r_eof     <= '0;
            r_cnt     <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_width  <= bus.img_width;
                r_height <= bus.img_height;
                r_addr   <= bus.base_addr;
                r_col    <= '0;
                r_row    <= '0;
            end
            if (w_issue) begin
                r_addr    <= r_addr + 1'b1;
                r_col     <= w_last_col ? '0 : r_col + 1'b1;
                r_row     <= w_last_col ? r_row + 1'b1 : r_row;
                r_inf_eol <= w_last_col;
                r_inf_eof <= w_last;
            end
            r_inf <= w_issue;
            if (r_inf) begin
                r_data[r_wp] <= bus.sram_rdata;
                r_eol[r_wp]  <= r_inf_eol;
                r_eof[r_wp]  <= r_inf_eof;
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= w_occ;
        end
    end

    assign bus.sram_rd_en = w_issue;
    assign bus.sram_addr  = r_addr;
    assign bus.pix_valid  = w_valid;
    assign bus.pix_data   = r_data[r_rp];
    assign bus.pix_eol    = w_valid && r_eol[r_rp];
    assign bus.pix_eof    = w_valid && r_eof[r_rp];
    assign bus.busy       = r_state == READ || r_state == DRAIN;
    assign bus.done       = r_state == DONE;
endmodule

// File: tb/tb_i_wr_sram_reader.sv
// tb_i_wr_sram_reader: randomized frames against a raster-order reference of addresses and tagged pixels.
module tb_i_wr_sram_reader;
    localparam int DB = 13;
    localparam int AB = 26;
    localparam int WB = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    i_wr_sram_reader_if #(.DIM_BITS(DB), .ADDR_BITS(AB), .DATA_BITS(WB)) bus ();

    i_wr_sram_reader #(.DIM_BITS(DB), .ADDR_BITS(AB), .DATA_BITS(WB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [WB-1:0] mem(input logic [AB-1:0] a);
        return {a[5:0], a} ^ 32'h5A5A_1234;
    endfunction

    // SRAM: data valid exactly one cycle after the strobe, garbage otherwise
    always @(posedge clk) bus.sram_rdata <= bus.sram_rd_en ? mem(bus.sram_addr) : $urandom;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(bus.sram_rd_en), 0);
        chk({tag, "_addr"}, 64'(bus.sram_addr), 0);
        chk({tag, "_valid"}, 64'(bus.pix_valid), 0);
        chk({tag, "_data"}, 64'(bus.pix_data), 0);
        chk({tag, "_eol"}, 64'(bus.pix_eol), 0);
        chk({tag, "_eof"}, 64'(bus.pix_eof), 0);
        chk({tag, "_busy"}, 64'(bus.busy), 0);
        chk({tag, "_done"}, 64'(bus.done), 0);
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low in cycles 3..7
    task automatic run_frame(input int w, input int h, input logic [AB-1:0] base, input int mode,
                             input int dup_cyc, input int rst_cyc);
        logic [AB-1:0]   exp_addr[$];
        logic [WB+1:0]   exp_pix[$];
        logic [AB-1:0]   a;
        logic [WB+1:0]   p;
        logic [WB-1:0]   held;
        logic            stall;
        int              n_rd, n_pop, n_val, n_done, done_cyc, eof_cyc, first_rd, first_v, limit;
        n_rd = 0; n_pop = 0; n_val = 0; n_done = 0;
        done_cyc = -1; eof_cyc = -1; first_rd = -1; first_v = -1;
        stall = 1'b0; held = '0;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                a = base + AB'(r * w + c);
                exp_addr.push_back(a);
                exp_pix.push_back({c == w - 1, (r == h - 1) && (c == w - 1), mem(a)});
            end
        bus.img_width  = DB'(w);
        bus.img_height = DB'(h);
        bus.base_addr  = base;
        bus.start      = 1'b1;
        bus.pix_ready  = mode != 2;
        limit = w * h * 6 + 30;
        @(posedge clk);
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            bus.start = cyc == dup_cyc;
            if (cyc == dup_cyc) begin
                bus.img_width  = 4;
                bus.img_height = 2;
                bus.base_addr  = 26'h300;
            end
            rst = cyc == rst_cyc;
            bus.pix_ready = mode == 0 ? 1'b1 : mode == 2 ? !(cyc >= 3 && cyc <= 7) : $urandom_range(0, 3) != 0;
            #1;
            if (cyc == rst_cyc + 1) begin
                chk_reset_outputs("midrst");
                return;
            end
            if (stall) begin
                chk("hold_valid", 64'(bus.pix_valid), 1);
                chk("hold_data", 64'(bus.pix_data), 64'(held));
            end
            stall = bus.pix_valid && !bus.pix_ready;
            held  = bus.pix_data;
            if (bus.sram_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                n_rd++;
                if (exp_addr.size() == 0) chk("extra_read", 1, 0);
                else chk("rd_addr", 64'(bus.sram_addr), 64'(exp_addr.pop_front()));
            end
            if (bus.pix_valid) begin
                if (first_v < 0) first_v = cyc;
                n_val++;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                n_pop++;
                if (exp_pix.size() == 0) chk("extra_pix", 1, 0);
                else begin
                    p = exp_pix.pop_front();
                    chk("pix_data", 64'(bus.pix_data), 64'(p[WB-1:0]));
                    chk("pix_eol", 64'(bus.pix_eol), 64'(p[WB+1]));
                    chk("pix_eof", 64'(bus.pix_eof), 64'(p[WB]));
                    if (p[WB]) eof_cyc = cyc;
                end
            end
            chk("outstanding_le2", 64'((n_rd - n_pop) <= 2), 1);
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_at_done", 64'(bus.busy), 0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 6) break;
        end
        chk("done_count", 64'(n_done), 1);
        chk("reads_left", 64'(exp_addr.size()), 0);
        chk("pix_left", 64'(exp_pix.size()), 0);
        if (w * h > 0) chk("done_after_eof", 64'(done_cyc), 64'(eof_cyc + 1));
        else begin
            chk("zero_done_cyc", 64'(done_cyc), 1);
            chk("zero_reads", 64'(n_rd), 0);
            chk("zero_valid", 64'(n_val), 0);
        end
        if (mode == 0 && w * h > 0) begin
            chk("first_rd_cyc", 64'(first_rd), 1);
            chk("first_valid_cyc", 64'(first_v), 3);
            chk("done_cyc", 64'(done_cyc), 64'(w * h + 3));
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.img_width  = '0;
        bus.img_height = '0;
        bus.base_addr  = '0;
        bus.pix_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        run_frame(4, 2, 26'h100, 0, -1, -1);
        run_frame(3, 1, 26'h040, 2, -1, -1);
        run_frame(0, 5, 26'h010, 0, -1, -1);
        run_frame(3, 0, 26'h020, 0, -1, -1);
        run_frame(4, 1, 26'h3FFFFFE, 0, -1, -1);
        run_frame(8, 8, 26'h800, 0, -1, 6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.pix_ready = 1'b1;
            #1;
            chk("post_rst_valid", 64'(bus.pix_valid), 0);
            chk("post_rst_rd_en", 64'(bus.sram_rd_en), 0);
        end
        run_frame(4, 2, 26'h100, 0, -1, -1);
        run_frame(4, 2, 26'h100, 0, 4, -1);
        for (int i = 0; i < 8; i++)
            run_frame($urandom_range(1, 6), $urandom_range(1, 4), AB'($urandom), 1, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
